ising_energy_scheduler: RTL and testbench

- Sequences the streaming sigma^T·J·sigma energy datapath for a stream of candidate spin vectors.
- For each candidate it:
  - latches sigma and pulses the datapath start;
  - issues the NUM_J_CHUNKS column-chunk read requests to J memory;
  - waits for the datapath done pulse;
  - compares the returned energy against the running best and keeps the lowest-energy sigma.
- Sits between the annealing/candidate generator (upstream) and the MatMul datapath plus J memory (downstream).

---
 rtl/ising_energy_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_ising_energy_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ising_energy_scheduler.sv
// ----------------------------------------------------------------------------
// ising_energy_scheduler
//
// Sequences the streaming sigma^T*J*sigma energy datapath over a stream of
// candidate spin vectors. For each candidate the block does the following:
//   1. latches sigma and the J base address, then pulses the datapath start;
//   2. issues NUM_J_CHUNKS consecutive J memory read requests;
//   3. waits for the datapath done pulse;
//   4. keeps the lowest-energy sigma seen so far.
//
// Optional build macro ISING_SCHED_WDOG_EN adds a watchdog on the WAIT state.
// When it is defined, the WDOG_CYCLES parameter is also available.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_base_addr              J base word address, sampled at candidate accept
//   clear                      synchronous clear of best/count/err
//   cand_valid/ready/sigma     candidate input handshake
//   mm_start, mm_sigma         datapath start pulse and stable sigma
//   mm_done, mm_energy         datapath completion pulse and signed energy
//   mem_req_valid/ready/addr   J memory read request channel
//   res_valid/energy/accept    per-evaluation result pulse
//   best_valid/energy/sigma    running best result
//   eval_count                 saturating count of completed evaluations
//   busy, err                  FSM not idle, sticky protocol error
//
// state  | meaning
// -------+-------------------------------------------------------------------
// IDLE   | ready for a candidate
// START  | one-cycle datapath start pulse
// FETCH  | issue J chunk reads, base + chunk_idx
// WAIT   | wait for datapath done (optionally watchdog-limited)
// UPDATE | publish result, update best and evaluation count
// ----------------------------------------------------------------------------
module ising_energy_scheduler #(
    parameter int VECTOR_SIZE     = 256,
    parameter int J_COLS_PER_READ = 4,
    parameter int NUM_J_CHUNKS    = VECTOR_SIZE / J_COLS_PER_READ,
    parameter int ENERGY_WIDTH    = 21,
    parameter int ADDR_WIDTH      = 16,
    parameter int CNT_WIDTH       = 16
`ifdef ISING_SCHED_WDOG_EN
    ,
    parameter int WDOG_CYCLES     = 1024
`endif
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          cfg_base_addr,
    input  logic                           clear,
    input  logic                           cand_valid,
    output logic                           cand_ready,
    input  logic [VECTOR_SIZE-1:0]         cand_sigma,
    output logic                           mm_start,
    output logic [VECTOR_SIZE-1:0]         mm_sigma,
    input  logic                           mm_done,
    input  logic signed [ENERGY_WIDTH-1:0] mm_energy,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic [ADDR_WIDTH-1:0]          mem_req_addr,
    output logic                           res_valid,
    output logic signed [ENERGY_WIDTH-1:0] res_energy,
    output logic                           res_accept,
    output logic                           best_valid,
    output logic signed [ENERGY_WIDTH-1:0] best_energy,
    output logic [VECTOR_SIZE-1:0]         best_sigma,
    output logic [CNT_WIDTH-1:0]           eval_count,
    output logic                           busy,
    output logic                           err
);

    localparam int CHUNK_W = (NUM_J_CHUNKS > 1) ? $clog2(NUM_J_CHUNKS) : 1;
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_J_CHUNKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FETCH,
        S_WAIT,
        S_UPDATE
    } state_t;

    state_t state, state_nxt;

    logic                           run_q;
    logic [CHUNK_W-1:0]             chunk_idx;
    logic [ADDR_WIDTH-1:0]          base_q;
    logic signed [ENERGY_WIDTH-1:0] energy_q;
    logic                           wdog_expired;
    logic                           wdog_fire;
    logic                           cand_hs;
    logic                           fetch_hs;
    logic                           early_done;
    logic                           new_best;

    // run_q keeps cand_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            run_q <= 1'b0;
        end else begin
            state <= state_nxt;
            run_q <= 1'b1;
        end
    end

    // mm_start and mem_req_valid decode the state directly. They therefore
    // drop as soon as reset asserts.
    always_comb begin
        state_nxt     = state;
        cand_ready    = 1'b0;
        mm_start      = 1'b0;
        mem_req_valid = 1'b0;
        wdog_fire     = 1'b0;
        res_valid     = 1'b0;
        case (state)
            S_IDLE: begin
                cand_ready = run_q;
                if (cand_valid && run_q) state_nxt = S_START;
            end
            S_START: begin
                mm_start  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready && (chunk_idx == LAST_CHUNK)) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mm_done) begin
                    state_nxt = S_UPDATE;
                end else if (wdog_expired) begin
                    wdog_fire = 1'b1;
                    res_valid = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_UPDATE: begin
                res_valid = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign cand_hs      = cand_valid && cand_ready;
    assign fetch_hs     = mem_req_valid && mem_req_ready;
    assign early_done   = mm_done && ((state == S_IDLE) || (state == S_START) || (state == S_FETCH));
    assign busy         = (state != S_IDLE);
    assign mem_req_addr = base_q + ADDR_WIDTH'(chunk_idx);
    assign res_energy   = (state == S_UPDATE) ? energy_q : '0;

    // A tie keeps the old best. A clear in the UPDATE cycle suppresses acceptance.
    assign new_best   = !best_valid || (energy_q < best_energy);
    assign res_accept = (state == S_UPDATE) && !clear && new_best;

`ifdef ISING_SCHED_WDOG_EN
    localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    logic [WDOG_W-1:0] wdog_cnt;

    // The watchdog counter is loaded on entry to WAIT and counts down.
    // It reaches zero in the WDOG_CYCLES-th WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
        end else if ((state != S_WAIT) && (state_nxt == S_WAIT)) begin
            wdog_cnt <= WDOG_W'(WDOG_CYCLES - 1);
        end else if ((state == S_WAIT) && (wdog_cnt != '0)) begin
            wdog_cnt <= wdog_cnt - 1'b1;
        end
    end

    assign wdog_expired = (wdog_cnt == '0);
`else
    assign wdog_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_sigma  <= '0;
            base_q    <= '0;
            chunk_idx <= '0;
            energy_q  <= '0;
        end else begin
            if (cand_hs) begin
                mm_sigma  <= cand_sigma;
                base_q    <= cfg_base_addr;
                chunk_idx <= '0;
            end else if (fetch_hs) begin
                chunk_idx <= chunk_idx + 1'b1;
            end
            if ((state == S_WAIT) && mm_done) energy_q <= mm_energy;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_valid  <= 1'b0;
            best_energy <= '0;
            best_sigma  <= '0;
            eval_count  <= '0;
            err         <= 1'b0;
        end else if (clear) begin
            best_valid  <= 1'b0;
            best_energy <= '0;
            best_sigma  <= '0;
            eval_count  <= '0;
            err         <= 1'b0;
        end else begin
            if (early_done || wdog_fire) err <= 1'b1;
            if (state == S_UPDATE) begin
                if (new_best) begin
                    best_valid  <= 1'b1;
                    best_energy <= energy_q;
                    best_sigma  <= mm_sigma;
                end
                if (eval_count != '1) eval_count <= eval_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ising_energy_scheduler.sv
module tb_ising_energy_scheduler;

    localparam int VS  = 256;
    localparam int NCH = 64;
    localparam int EW  = 21;
    localparam int AW  = 16;
    localparam int CW  = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [AW-1:0]        cfg_base_addr;
    logic                 clear;
    logic                 cand_valid;
    logic                 cand_ready;
    logic [VS-1:0]        cand_sigma;
    logic                 mm_start;
    logic [VS-1:0]        mm_sigma;
    logic                 mm_done;
    logic signed [EW-1:0] mm_energy;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [AW-1:0]        mem_req_addr;
    logic                 res_valid;
    logic signed [EW-1:0] res_energy;
    logic                 res_accept;
    logic                 best_valid;
    logic signed [EW-1:0] best_energy;
    logic [VS-1:0]        best_sigma;
    logic [CW-1:0]        eval_count;
    logic                 busy;
    logic                 err;

    ising_energy_scheduler #(
        .VECTOR_SIZE(VS), .J_COLS_PER_READ(4), .NUM_J_CHUNKS(NCH),
        .ENERGY_WIDTH(EW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
`ifdef ISING_SCHED_WDOG_EN
        , .WDOG_CYCLES(16)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_base_addr(cfg_base_addr), .clear(clear),
        .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_sigma(cand_sigma),
        .mm_start(mm_start), .mm_sigma(mm_sigma), .mm_done(mm_done), .mm_energy(mm_energy),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .res_valid(res_valid), .res_energy(res_energy), .res_accept(res_accept),
        .best_valid(best_valid), .best_energy(best_energy), .best_sigma(best_sigma),
        .eval_count(eval_count), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus monitor: samples mid-cycle, when inputs and outputs are settled.
    int           cyc = 0;
    int           start_cnt = 0;
    int           res_seen = 0;
    logic         last_acc = 1'b0;
    logic         stall_pend = 1'b0;
    logic [AW-1:0] stall_addr = '0;
    logic [AW-1:0] addr_q[$];
    int           cyc_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_pend = 1'b0;
        end else begin
            if (mm_start) start_cnt++;
            if (stall_pend) check("stall_hold", {mem_req_valid, mem_req_addr}, {1'b1, stall_addr});
            if (mem_req_valid && mem_req_ready) begin
                addr_q.push_back(mem_req_addr);
                cyc_q.push_back(cyc);
            end
            stall_pend = mem_req_valid && !mem_req_ready;
            stall_addr = mem_req_addr;
            if (res_valid) begin
                res_seen++;
                last_acc = res_accept;
            end
        end
    end

    // Memory ready driver. Mode 0 keeps ready high, mode 1 repeats the
    // pattern 1,0,0, and mode 2 drives random ready values.
    int rdy_mode = 0;
    initial begin
        int p;
        p = 0;
        mem_req_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       mem_req_ready = 1'b1;
                1:       begin mem_req_ready = (p % 3 == 0); p++; end
                default: mem_req_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference model of the best-so-far state.
    logic                 m_valid;
    logic signed [EW-1:0] m_best;
    logic [VS-1:0]        m_sigma;
    logic [CW-1:0]        m_count;
    logic                 m_err;

    task automatic model_clear();
        m_valid = 1'b0; m_best = '0; m_sigma = '0; m_count = '0; m_err = 1'b0;
    endtask

    function automatic logic [VS-1:0] rand_sigma();
        logic [VS-1:0] s;
        for (int i = 0; i < VS / 32; i++) s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    // corner: 0 normal, 1 mm_done pulsed during FETCH, 2 clear during UPDATE
    task automatic run_eval(input logic [VS-1:0] sig, input logic [AW-1:0] base,
                            input logic signed [EW-1:0] e, input int dly, input int corner);
        int n;
        int st0;
        int rs0;
        logic exp_acc;
        logic ok;
        addr_q.delete();
        cyc_q.delete();
        st0 = start_cnt;
        rs0 = res_seen;
        check("idle_ready", cand_ready, 1);
        cand_sigma = sig; cfg_base_addr = base; cand_valid = 1'b1;
        tick();
        cand_valid = 1'b0; cand_sigma = ~sig; cfg_base_addr = ~base;
        check("busy_after_accept", busy, 1);
        check("ready_low_when_busy", cand_ready, 0);
        n = 0;
        while (addr_q.size() < NCH && n < 5000) begin
            mm_done = (corner == 1 && n == 2);
            tick();
            n++;
        end
        mm_done = 1'b0;
        if (n >= 5000) check("fetch_timeout", addr_q.size(), NCH);
        check("handshake_count", addr_q.size(), NCH);
        ok = 1'b1;
        for (int i = 0; i < NCH && i < addr_q.size(); i++)
            if (addr_q[i] !== AW'(base + AW'(i))) ok = 1'b0;
        check("addr_sequence", ok, 1);
        if (rdy_mode == 0 && cyc_q.size() == NCH) check("fetch_back_to_back", cyc_q[NCH-1] - cyc_q[0], NCH - 1);
        check("start_pulses", start_cnt - st0, 1);
        check("mm_sigma_held", mm_sigma, sig);
        repeat (dly - 1) tick();
        mm_done = 1'b1; mm_energy = e;
        tick();
        mm_done = 1'b0; mm_energy = EW'($urandom);
        if (corner == 2) clear = 1'b1;
        if (corner == 1) m_err = 1'b1;
        exp_acc = (corner != 2) && (!m_valid || e < m_best);
        #3;
        check("res_valid", res_valid, 1);
        check("res_accept_model", res_accept, exp_acc);
        check("res_energy", res_energy, e);
        tick();
        clear = 1'b0;
        if (corner == 2) begin
            model_clear();
        end else begin
            if (exp_acc) begin m_valid = 1'b1; m_best = e; m_sigma = sig; end
            if (m_count != '1) m_count = m_count + 1'b1;
        end
        check("res_pulse_count", res_seen - rs0, 1);
        check("idle_after_update", busy, 0);
        check("best_valid", best_valid, m_valid);
        check("best_energy_model", best_energy, m_best);
        check("best_sigma", best_sigma, m_sigma);
        check("eval_count_model", eval_count, m_count);
        check("err_model", err, m_err);
    endtask

    typedef struct {
        logic                 clr;
        logic [AW-1:0]        base;
        logic signed [EW-1:0] energy;
        int                   rmode;
        int                   corner;
        logic                 exp_acc;
        logic signed [EW-1:0] exp_best;
        logic [CW-1:0]        exp_cnt;
        logic                 exp_err;
    } vec_t;

    vec_t vt[6];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic signed [EW-1:0] e;
        int k;
        vt[0] = '{1'b0, 16'h0100, -21'sd37,    0, 0, 1'b1, -21'sd37,    16'd1, 1'b0};
        vt[1] = '{1'b1, 16'h0200, 21'sd12,     1, 0, 1'b1, 21'sd12,     16'd1, 1'b0};
        vt[2] = '{1'b0, 16'hFFF0, -21'sd5,     0, 0, 1'b1, -21'sd5,     16'd2, 1'b0};
        vt[3] = '{1'b0, 16'h1234, -21'sd5,     1, 0, 1'b0, -21'sd5,     16'd3, 1'b0};
        vt[4] = '{1'b0, 16'h0040, 21'h100000,  2, 1, 1'b1, 21'h100000,  16'd4, 1'b1};
        vt[5] = '{1'b0, 16'h7FFF, 21'h0FFFFF,  0, 2, 1'b0, 21'sd0,      16'd0, 1'b0};

        rst_n = 1'b0; clear = 1'b0; cand_valid = 1'b1; cand_sigma = rand_sigma();
        cfg_base_addr = 16'h5555; mm_done = 1'b0; mm_energy = '0;
        model_clear();
        repeat (3) tick();
        check("rst_cand_ready", cand_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_outputs", {mm_start, mem_req_valid, res_valid, res_accept, best_valid, err}, 0);
        check("rst_values", {mm_sigma, best_sigma, best_energy, eval_count, res_energy, mem_req_addr}, 0);
        rst_n = 1'b1; cand_valid = 1'b0;
        check("ready_low_at_release", cand_ready, 0);
        tick();
        check("ready_after_release", cand_ready, 1);

        for (int i = 0; i < 6; i++) begin
            if (vt[i].clr) begin
                clear = 1'b1; tick(); clear = 1'b0; model_clear();
            end
            rdy_mode = vt[i].rmode;
            run_eval(rand_sigma(), vt[i].base, vt[i].energy, 5, vt[i].corner);
            check("tbl_res_accept", last_acc, vt[i].exp_acc);
            check("tbl_best_energy", best_energy, vt[i].exp_best);
            check("tbl_eval_count", eval_count, vt[i].exp_cnt);
            check("tbl_err", err, vt[i].exp_err);
        end

        for (int i = 0; i < 10; i++) begin
            rdy_mode = $urandom_range(0, 2);
            e = (($urandom & 3) == 0) ? m_best : EW'($urandom);
            run_eval(rand_sigma(), AW'($urandom), e, $urandom_range(1, 6), 0);
        end

        cand_sigma = rand_sigma(); cfg_base_addr = 16'h0300; cand_valid = 1'b1; rdy_mode = 1;
        tick();
        cand_valid = 1'b0;
        repeat (5) tick();
        check("midrst_fetching", mem_req_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_async_drop", {mem_req_valid, mm_start, busy}, 0);
        check("midrst_cleared", {best_valid, eval_count}, 0);
        tick();
        rst_n = 1'b1;
        model_clear();
        tick();
        check("midrst_idle_ready", cand_ready, 1);

`ifdef ISING_SCHED_WDOG_EN
        rdy_mode = 0;
        addr_q.delete();
        cand_sigma = rand_sigma(); cfg_base_addr = 16'h0000; cand_valid = 1'b1;
        tick();
        cand_valid = 1'b0;
        k = 0;
        while (addr_q.size() < NCH && k < 5000) begin tick(); k++; end
        k = 1;
        #3;
        while (!res_valid && k < 40) begin tick(); #3; k++; end
        check("wdog_fire_cycle", k, 16);
        check("wdog_err", err, 1);
        check("wdog_res", {res_accept, res_energy}, 0);
        tick();
        m_err = 1'b1;
        check("wdog_idle", busy, 0);
        check("wdog_count_kept", eval_count, m_count);
        check("wdog_best_kept", best_valid, m_valid);
`else
        k = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
